// File: rtl/image_filter_writer.sv
// Offline point/3x3 filter engine: streams one stored grayscale image out of the
// frame RAM, filters it and writes the result into the filtered-image region.
module image_filter_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  select_image,
    input  logic [1:0]  filter_sel,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [1:0]  result_image
);

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 8;
    localparam int unsigned CW   = 9;
    localparam int unsigned TW   = 4;
    localparam int unsigned ACCW = 13;

    localparam logic [AW-1:0] OUT_OFFSET = AW'(373500);
    localparam logic [1:0]    F_COPY     = 2'd0;
    localparam logic [1:0]    F_BLUR     = 2'd1;
    localparam logic [1:0]    F_SHARP    = 2'd2;
    localparam logic [1:0]    F_INV      = 2'd3;
    localparam logic [TW-1:0] TAP_CENTER = TW'(4);
    localparam logic [TW-1:0] TAP_LAST   = TW'(8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LAST,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [1:0]           sel_q, sel_d;
    logic [1:0]           filt_q, filt_d;
    logic [CW-1:0]        side_q, side_d;
    logic [AW-1:0]        off_q, off_d;
    logic [CW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic [TW-1:0]        tap_q, tap_d;
    logic [TW-1:0]        cap_tap_q, cap_tap_d;
    logic                 kern_q, kern_d;
    logic                 rd_pend_q, rd_pend_d;
    logic signed [ACCW-1:0] acc_q, acc_d;

    logic [AW-1:0]        mem_addr_q, mem_addr_d;
    logic                 mem_we_q, mem_we_d;
    logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [1:0]           result_q, result_d;

    logic                 accept_c;
    logic                 last_tap_c;
    logic                 last_pix_c;
    logic signed [ACCW-1:0] pix_c;
    logic signed [ACCW-1:0] tap_sum_c;
    logic [DW-1:0]        result_c;

    function automatic logic [CW-1:0] img_side(input logic [1:0] s);
        case (s)
            2'd0:    img_side = CW'(400);
            2'd1:    img_side = CW'(350);
            default: img_side = CW'(300);
        endcase
    endfunction

    function automatic logic [AW-1:0] img_offset(input logic [1:0] s);
        case (s)
            2'd0:    img_offset = AW'(1000);
            2'd1:    img_offset = AW'(161000);
            default: img_offset = AW'(283500);
        endcase
    endfunction

    // Address offset of tap t (row-major dr,dc in -1..1) relative to the centre
    function automatic logic [AW-1:0] tap_off(input logic [TW-1:0] t, input logic [CW-1:0] s);
        logic [AW-1:0] sw;
        sw = AW'(s);
        case (t)
            TW'(0):  tap_off = AW'(0) - sw - AW'(1);
            TW'(1):  tap_off = AW'(0) - sw;
            TW'(2):  tap_off = AW'(0) - sw + AW'(1);
            TW'(3):  tap_off = AW'(0) - AW'(1);
            TW'(5):  tap_off = AW'(1);
            TW'(6):  tap_off = sw - AW'(1);
            TW'(7):  tap_off = sw;
            TW'(8):  tap_off = sw + AW'(1);
            default: tap_off = '0;
        endcase
    endfunction

    function automatic logic signed [ACCW-1:0] tap_weight(input logic [TW-1:0] t,
                                                          input logic kern,
                                                          input logic [1:0] filt);
        tap_weight = '0;
        if (!kern) begin
            if (t == TAP_CENTER) tap_weight = ACCW'(1);
        end else if (filt == F_BLUR) begin
            case (t)
                TW'(0), TW'(2), TW'(6), TW'(8): tap_weight = ACCW'(1);
                TW'(1), TW'(3), TW'(5), TW'(7): tap_weight = ACCW'(2);
                TW'(4):                         tap_weight = ACCW'(4);
                default:                        tap_weight = '0;
            endcase
        end else begin
            case (t)
                TW'(1), TW'(3), TW'(5), TW'(7): tap_weight = ACCW'(-1);
                TW'(4):                         tap_weight = ACCW'(5);
                default:                        tap_weight = '0;
            endcase
        end
    endfunction

    assign accept_c   = (state_q == S_IDLE) && start && (select_image != 2'd3);
    assign last_tap_c = kern_q ? (tap_q == TAP_LAST) : 1'b1;
    assign last_pix_c = (row_q == side_q - CW'(1)) && (col_q == side_q - CW'(1));

    // Tap data arrives one cycle after its address; fold it in as it lands
    assign pix_c     = $signed({{(ACCW-DW){1'b0}}, mem_rdata});
    assign tap_sum_c = rd_pend_q ? acc_q + tap_weight(cap_tap_q, kern_q, filt_q) * pix_c : acc_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c) state_d = S_READ;
            S_READ:  if (last_tap_c) state_d = S_LAST;
            S_LAST:  state_d = S_WRITE;
            S_WRITE: state_d = last_pix_c ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        result_c = tap_sum_c[DW-1:0];
        case (filt_q)
            F_INV:  result_c = DW'(255) - tap_sum_c[DW-1:0];
            F_BLUR: if (kern_q) result_c = tap_sum_c[DW+3:4];
            F_SHARP: begin
                if (kern_q) begin
                    if (tap_sum_c[ACCW-1])          result_c = '0;
                    else if (|tap_sum_c[ACCW-2:DW]) result_c = '1;
                end
            end
            default: result_c = tap_sum_c[DW-1:0];
        endcase
    end

    // Datapath and registered outputs, all computed for the upcoming state
    always_comb begin
        sel_d       = sel_q;
        filt_d      = filt_q;
        side_d      = side_q;
        off_d       = off_q;
        row_d       = row_q;
        col_d       = col_q;
        tap_d       = tap_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        result_d    = result_q;

        if (accept_c) begin
            sel_d  = select_image;
            filt_d = filter_sel;
            side_d = img_side(select_image);
            off_d  = img_offset(select_image);
            row_d  = '0;
            col_d  = '0;
        end else if (state_q == S_WRITE && !last_pix_c) begin
            if (col_q == side_q - CW'(1)) begin
                col_d = '0;
                row_d = row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        kern_d = ((filt_d == F_BLUR) || (filt_d == F_SHARP)) &&
                 (row_d != '0) && (row_d != side_d - CW'(1)) &&
                 (col_d != '0) && (col_d != side_d - CW'(1));

        if (state_d == S_READ)
            tap_d = (state_q == S_READ) ? tap_q + TW'(1) : (kern_d ? '0 : TAP_CENTER);

        rd_pend_d = (state_q == S_READ);
        cap_tap_d = tap_q;
        acc_d     = (state_q == S_READ || state_q == S_LAST) ? tap_sum_c : '0;

        if (state_d == S_READ)
            mem_addr_d = off_d + AW'(row_d) * AW'(side_d) + AW'(col_d) + tap_off(tap_d, side_d);
        else if (state_d == S_WRITE)
            mem_addr_d = OUT_OFFSET + AW'(row_q) * AW'(side_q) + AW'(col_q);

        if (state_d == S_WRITE) mem_wdata_d = result_c;
        if (state_d == S_DONE)  result_d    = sel_q;

        mem_we_d = (state_d == S_WRITE);
        busy_d   = (state_d == S_READ) || (state_d == S_LAST) || (state_d == S_WRITE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q       <= '0;
            filt_q      <= '0;
            side_q      <= '0;
            off_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            tap_q       <= '0;
            cap_tap_q   <= '0;
            kern_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            acc_q       <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            sel_q       <= sel_d;
            filt_q      <= filt_d;
            side_q      <= side_d;
            off_q       <= off_d;
            row_q       <= row_d;
            col_q       <= col_d;
            tap_q       <= tap_d;
            cap_tap_q   <= cap_tap_d;
            kern_q      <= kern_d;
            rd_pend_q   <= rd_pend_d;
            acc_q       <= acc_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_image = result_q;

endmodule
